simple_pipe_feeder: RTL and testbench

Instruction feeder and register-file sampler that drives the 4-register, 3-stage `pipeline_v` core from the producer side. It holds a small program loaded through a write port and issues it one 8-bit instruction per cycle on `inst`, with optional bubble insertion. It waits out the pipeline depth, then sweeps the core's `dummy_read_rf`/`dummy_rf_data` port to snapshot all four architectural registers. It sits between the test harness (or ILA-level driver) and `pipeline_v`.

---
 rtl/simple_pipe_feeder.sv | 169 ++++++++++++++++
 tb/tb_simple_pipe_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_pipe_feeder.sv
// Instruction feeder and register-file sampler for the 4-register, 3-stage pipeline_v core.
// Issues a stored program one instruction per cycle, waits out write-back, then snapshots r0..r3.
module simple_pipe_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DRAIN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          hold,
    output logic [7:0]    inst,
    output logic [1:0]    dummy_read_rf,
    input  logic [7:0]    dummy_rf_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   inst_count,
    output logic [31:0]   rf_snap
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_READ,
        S_DONE
    } state_t;

    localparam int            CW        = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
    localparam logic [CW-1:0] DRAIN_W   = CW'(DRAIN);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PC_ONE    = AW'(1);

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   pc;
    logic [AW:0]     len;
    logic [AW:0]     len_clip;
    logic [CW-1:0]   drain_cnt;
    logic [1:0]      idx;
    logic            last_issue;
    logic            prog_open;

    assign len_clip   = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
    assign last_issue = ({1'b0, pc} == (len - LEN_ONE));
    // Loading is only safe when nothing is reading the program.
    assign prog_open  = (state == S_IDLE) || (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (len_clip == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!hold && last_issue) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == CNT_ONE) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                if (idx == 2'd3) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        inst          = 8'h00;
        dummy_read_rf = 2'd0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_ISSUE: begin
                busy = 1'b1;
                if (!hold) begin
                    inst = mem[pc];
                end
            end
            S_DRAIN: busy = 1'b1;
            S_READ: begin
                busy          = 1'b1;
                dummy_read_rf = idx;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            len        <= '0;
            drain_cnt  <= '0;
            idx        <= '0;
            inst_count <= '0;
            rf_snap    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len        <= len_clip;
                        pc         <= '0;
                        inst_count <= '0;
                        rf_snap    <= '0;
                        drain_cnt  <= DRAIN_W;
                    end
                end
                S_ISSUE: begin
                    if (!hold) begin
                        pc         <= pc + PC_ONE;
                        inst_count <= inst_count + LEN_ONE;
                        if (last_issue) begin
                            drain_cnt <= DRAIN_W;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt - CNT_ONE;
                    if (drain_cnt == CNT_ONE) begin
                        idx <= '0;
                    end
                end
                S_READ: begin
                    rf_snap[8*idx +: 8] <= dummy_rf_data;
                    idx                 <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the program store is built from resettable flops so a reset leaves every entry a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (prog_we && prog_open) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_simple_pipe_feeder.sv
// Scoreboard bench for simple_pipe_feeder: stimulus queues expected issues and run results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_simple_pipe_feeder;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        hold;
    logic [7:0]  inst;
    logic [1:0]  dummy_read_rf;
    logic [7:0]  dummy_rf_data;
    logic        busy;
    logic        done;
    logic [4:0]  inst_count;
    logic [31:0] rf_snap;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } inst_e;

    typedef struct {
        int          cyc;
        logic [31:0] snap;
        logic [4:0]  cnt;
    } done_e;

    inst_e      inst_q[$];
    done_e      done_q[$];
    logic [7:0] mem_m [16];
    int         cyc;
    int         total;
    int         bad;

    simple_pipe_feeder #(.DEPTH(16), .AW(4), .DRAIN(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .prog_len      (prog_len),
        .start         (start),
        .hold          (hold),
        .inst          (inst),
        .dummy_read_rf (dummy_read_rf),
        .dummy_rf_data (dummy_rf_data),
        .busy          (busy),
        .done          (done),
        .inst_count    (inst_count),
        .rf_snap       (rf_snap)
    );

    assign dummy_rf_data = 8'hA0 | {6'd0, dummy_read_rf};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every visible issue and every done pulse against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (inst != 8'h00) begin
                if (inst_q.size() == 0) begin
                    check("unexpected_inst", {24'd0, inst}, 32'd0);
                end else begin
                    inst_e e;
                    e = inst_q.pop_front();
                    check("inst_val", {24'd0, inst}, {24'd0, e.val});
                    check("inst_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_e d;
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("rf_snap", rf_snap, d.snap);
                    check("inst_count", {27'd0, inst_count}, {27'd0, d.cnt});
                end
            end
        end
    end

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        mem_m[a]  = d;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
    endtask

    // One full run; hmask bit k holds in run cycle k; inj_off>0 pokes start+write mid-run.
    task automatic run(input int plen, input logic [31:0] hmask, input int inj_off);
        int    n;
        int    nh;
        int    idx;
        int    off;
        int    s;
        int    doff;
        done_e d;
        n = (plen > 16) ? 16 : plen;
        @(posedge clk);
        #1;
        prog_len = 5'(plen);
        start    = 1'b1;
        s        = cyc;
        nh  = 0;
        idx = 0;
        off = 1;
        while (idx < n) begin
            if (hmask[off]) begin
                nh++;
            end else begin
                if (mem_m[idx] != 8'h00) inst_q.push_back('{cyc: s + off, val: mem_m[idx]});
                idx++;
            end
            off++;
        end
        doff   = n + 7 + nh;
        d.cyc  = s + doff;
        d.snap = 32'hA3A2A1A0;
        d.cnt  = 5'(n);
        done_q.push_back(d);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= doff; k++) begin
            hold = hmask[k];
            if (inj_off > 0 && k == inj_off) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd0;
                prog_data = 8'hFF;
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            @(negedge clk);
            check("busy", {31'd0, busy}, {31'd0, (k < doff)});
            if (k >= doff - 4 && k < doff)
                check("read_idx", {30'd0, dummy_read_rf}, 32'(k - (doff - 4)));
            else
                check("read_idx_idle", {30'd0, dummy_read_rf}, 32'd0);
            @(posedge clk);
            #1;
        end
        hold    = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    initial begin
        int s;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        hold      = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst", {24'd0, inst}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdidx", {30'd0, dummy_read_rf}, 32'd0);
        check("rst_count", {27'd0, inst_count}, 32'd0);
        check("rst_snap", rf_snap, 32'd0);
        rst_n = 1'b1;
        run(0, 32'd0, 0);
        run(3, 32'd0, 0);

        // Basic run
        prog(4'd0, 8'h41);
        prog(4'd1, 8'h86);
        prog(4'd2, 8'hC7);
        run(3, 32'd0, 0);

        // Hold in run cycle 2
        run(3, 32'h4, 0);

        // Empty length
        run(0, 32'd0, 0);

        // Busy protections, then confirm mem[0] survived
        run(3, 32'd0, 2);
        run(1, 32'd0, 0);

        // Clipped length
        for (int i = 0; i < 16; i++) prog(4'(i), 8'(8'h10 + i));
        run(20, 32'd0, 0);

        // Reset mid-run
        prog(4'd0, 8'h41);
        prog(4'd1, 8'h86);
        prog(4'd2, 8'hC7);
        @(posedge clk);
        #1;
        prog_len = 5'd3;
        start    = 1'b1;
        s        = cyc;
        inst_q.push_back('{cyc: s + 1, val: 8'h41});
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_inst", {24'd0, inst}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_count", {27'd0, inst_count}, 32'd0);
        check("midrst_snap", rf_snap, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        run(3, 32'd0, 0);

        repeat (3) @(posedge clk);
        check("inst_q_empty", inst_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
